serial_target_port_p: RTL and testbench

- Parametrised next-generation target-side port for the serial bus. Sits between the bus and one target.
- RX path: deserialises an ADDR_W-bit address and, for writes, a DATA_W-bit data word, then presents one request with a valid/ready handshake.
- TX path: buffers target read data in a TX_DEPTH FIFO and serialises it LSB-first onto the bus.
- Split arbitration signals pass through unchanged.

---
 rtl/serial_bus_pkg.sv | 18 +
 rtl/stp_sync_fifo.sv | 56 +++++
 rtl/serial_target_port_p.sv | 253 +++++++++++++++++++++++++
 tb/tb_serial_target_port_p.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types for the serial bus target port: RX/TX state encodings and bus_mode values.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    RX_ADDR = 2'd0,
    RX_DATA = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  localparam logic BUS_MODE_ADDR = 1'b0;
  localparam logic BUS_MODE_DATA = 1'b1;

endpackage

// File: rtl/stp_sync_fifo.sv
// Single-clock FIFO for target read data; DEPTH must be a power of 2 so pointers wrap naturally.
module stp_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // Pop is gated by the registered empty flag, so a word pushed into an empty FIFO is never bypassed.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/serial_target_port_p.sv
// Target-side serial bus port: RX deserialiser/request FSM, TX read-data FIFO and serialiser.
// Define SERIAL_TGT_PARITY_EN to add an even-parity bit after every address, data and TX word.
module serial_target_port_p
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bus_data_in,
  input  logic                        bus_data_in_valid,
  input  logic                        bus_mode,
  input  logic                        bus_rw,
  output logic                        bus_data_out,
  output logic                        bus_data_out_valid,
  output logic                        tgt_req_valid,
  input  logic                        tgt_req_ready,
  output logic [ADDR_W-1:0]           tgt_req_addr,
  output logic                        tgt_req_write,
  output logic [DATA_W-1:0]           tgt_req_wdata,
  input  logic [DATA_W-1:0]           tgt_rdata,
  input  logic                        tgt_rdata_valid,
  output logic                        tgt_rdata_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_fifo_count,
  output logic                        rx_drop,
  input  logic                        split_req,
  input  logic                        arbiter_grant,
  output logic                        arbiter_split_req,
  output logic                        split_grant
);

`ifdef SERIAL_TGT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int MAX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(MAX_W + 2);
  localparam int TXC_W   = $clog2(DATA_W + 2);
  localparam int TX_LAST = DATA_W - 1 + int'(PAR_EN);

  // RX state
  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              rx_drop_q, rx_drop_d;
  logic              tx_busy;

  // TX state
  tx_state_t         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_par_q, tx_par_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign arbiter_split_req = split_req;
  assign split_grant       = arbiter_grant;

  assign tx_busy = (tx_state_q == TX_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_ADDR;
      rx_cnt_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  // NOTE: every comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rx_drop_d  = 1'b0;
    unique case (rx_state_q)
      RX_ADDR: begin
        if (bus_data_in_valid) begin
          if (tx_busy || bus_mode != BUS_MODE_ADDR) begin
            rx_drop_d = 1'b1;
          end else if (PAR_EN && rx_cnt_q == CNT_W'(ADDR_W)) begin
            if (bus_data_in != ^addr_q) begin
              rx_drop_d  = 1'b1;
              rx_state_d = RX_ADDR;
              rx_cnt_d   = '0;
              addr_d     = '0;
              write_d    = 1'b0;
            end else begin
              rx_cnt_d   = '0;
              rx_state_d = write_q ? RX_DATA : RX_HOLD;
            end
          end else begin
            // LSB-first: each bit enters at the top and ends at its own index after ADDR_W shifts.
            addr_d   = {bus_data_in, addr_q[ADDR_W-1:1]};
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            if (rx_cnt_q == CNT_W'(ADDR_W - 1)) begin
              write_d = bus_rw;
              if (!PAR_EN) begin
                rx_cnt_d   = '0;
                rx_state_d = bus_rw ? RX_DATA : RX_HOLD;
              end
            end
          end
        end
      end
      RX_DATA: begin
        if (bus_data_in_valid) begin
          if (tx_busy || bus_mode != BUS_MODE_DATA) begin
            rx_drop_d = 1'b1;
          end else if (PAR_EN && rx_cnt_q == CNT_W'(DATA_W)) begin
            if (bus_data_in != ^wdata_q) begin
              rx_drop_d  = 1'b1;
              rx_state_d = RX_ADDR;
              rx_cnt_d   = '0;
              addr_d     = '0;
              wdata_d    = '0;
              write_d    = 1'b0;
            end else begin
              rx_cnt_d   = '0;
              rx_state_d = RX_HOLD;
            end
          end else begin
            wdata_d  = {bus_data_in, wdata_q[DATA_W-1:1]};
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            if (!PAR_EN && rx_cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_cnt_d   = '0;
              rx_state_d = RX_HOLD;
            end
          end
        end
      end
      RX_HOLD: begin
        rx_drop_d = bus_data_in_valid;
        if (tgt_req_ready) begin
          rx_state_d = RX_ADDR;
          rx_cnt_d   = '0;
          addr_d     = '0;
          wdata_d    = '0;
          write_d    = 1'b0;
        end
      end
      default: rx_state_d = RX_ADDR;
    endcase
  end

  // Request fields are exposed only while valid, so they read as zero at all other times.
  always_comb begin
    tgt_req_valid = (rx_state_q == RX_HOLD);
    tgt_req_addr  = tgt_req_valid ? addr_q : '0;
    tgt_req_write = tgt_req_valid && write_q;
    tgt_req_wdata = tgt_req_valid ? wdata_q : '0;
  end

  assign rx_drop = rx_drop_q;

  assign tgt_rdata_ready = !fifo_full;
  assign fifo_push       = tgt_rdata_valid && !fifo_full;

  stp_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (tgt_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (tx_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      shift_q      <= '0;
      tx_cnt_q     <= '0;
      tx_par_q     <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      shift_q      <= shift_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_par_q     <= tx_par_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          shift_d    = fifo_rdata;
          tx_par_d   = ^fifo_rdata;
          tx_cnt_d   = '0;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        shift_d  = {1'b0, shift_q[DATA_W-1:1]};
        tx_cnt_d = tx_cnt_q + TXC_W'(1);
        if (tx_cnt_q == TXC_W'(TX_LAST)) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Output bits are registered, giving the one-cycle gap between pop and the first bus bit.
  always_comb begin
    fifo_pop     = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:  fifo_pop = !fifo_empty;
      TX_SHIFT: begin
        dout_valid_d = 1'b1;
        dout_d       = (tx_cnt_q < TXC_W'(DATA_W)) ? shift_q[0] : tx_par_q;
      end
      default: fifo_pop = 1'b0;
    endcase
  end

  assign bus_data_out       = dout_q;
  assign bus_data_out_valid = dout_valid_q;

endmodule

// File: tb/tb_serial_target_port_p.sv
// Directed self-checking bench for serial_target_port_p; adapts to SERIAL_TGT_PARITY_EN.
module tb_serial_target_port_p;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int TX_DEPTH = 4;
`ifdef SERIAL_TGT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic                      clk, rst_n;
  logic                      bus_data_in, bus_data_in_valid, bus_mode, bus_rw;
  logic                      bus_data_out, bus_data_out_valid;
  logic                      tgt_req_valid, tgt_req_ready, tgt_req_write;
  logic [ADDR_W-1:0]         tgt_req_addr;
  logic [DATA_W-1:0]         tgt_req_wdata, tgt_rdata;
  logic                      tgt_rdata_valid, tgt_rdata_ready;
  logic [$clog2(TX_DEPTH):0] tx_fifo_count;
  logic                      rx_drop;
  logic                      split_req, arbiter_grant, arbiter_split_req, split_grant;

  int n_cmp = 0;
  int n_bad = 0;

  serial_target_port_p #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TX_DEPTH (TX_DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_data_in        (bus_data_in),
    .bus_data_in_valid  (bus_data_in_valid),
    .bus_mode           (bus_mode),
    .bus_rw             (bus_rw),
    .bus_data_out       (bus_data_out),
    .bus_data_out_valid (bus_data_out_valid),
    .tgt_req_valid      (tgt_req_valid),
    .tgt_req_ready      (tgt_req_ready),
    .tgt_req_addr       (tgt_req_addr),
    .tgt_req_write      (tgt_req_write),
    .tgt_req_wdata      (tgt_req_wdata),
    .tgt_rdata          (tgt_rdata),
    .tgt_rdata_valid    (tgt_rdata_valid),
    .tgt_rdata_ready    (tgt_rdata_ready),
    .tx_fifo_count      (tx_fifo_count),
    .rx_drop            (rx_drop),
    .split_req          (split_req),
    .arbiter_grant      (arbiter_grant),
    .arbiter_split_req  (arbiter_split_req),
    .split_grant        (split_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic mode, input logic rw);
    bus_data_in       = b;
    bus_mode          = mode;
    bus_rw            = rw;
    bus_data_in_valid = 1'b1;
    tick();
    bus_data_in_valid = 1'b0;
    bus_rw            = 1'b0;
  endtask

  // Sends address bits lo..hi; the parity bit follows automatically after the last address bit.
  task automatic send_addr_range(input logic [15:0] a, input int lo, input int hi, input logic rw);
    for (int i = lo; i <= hi; i++) send_bit(a[i], 1'b0, (i == ADDR_W - 1) ? rw : 1'b0);
    if (PB != 0 && hi == ADDR_W - 1) send_bit(^a, 1'b0, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], 1'b1, 1'b0);
    if (PB != 0) send_bit(^d, 1'b1, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    tgt_rdata       = d;
    tgt_rdata_valid = 1'b1;
    tick();
    tgt_rdata_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n;
    n = 0;
    while (bus_data_out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, (n < 40), 1);
  endtask

  task automatic recv_word(input string tag, output logic [7:0] w, output logic p);
    int   n;
    logic all_valid;
    n = 0;
    w = '0;
    p = 1'b0;
    all_valid = 1'b1;
    while (!bus_data_out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_start"}, (n < 40), 1);
    for (int i = 0; i < DATA_W + PB; i++) begin
      all_valid &= bus_data_out_valid;
      if (i < DATA_W) w[i] = bus_data_out;
      else            p    = bus_data_out;
      tick();
    end
    check({tag, "_valid"}, all_valid, 1);
    if (PB != 0) check({tag, "_parity"}, p, ^w);
  endtask

  function automatic logic [7:0] w96();
    return 8'h96;
  endfunction

  logic [7:0] rw_word;
  logic       rw_par;
  logic [7:0] exp_words [4];
  logic [7:0] tx_word;

  initial begin
    rst_n = 1'b0;
    bus_data_in = 1'b0; bus_data_in_valid = 1'b0; bus_mode = 1'b0; bus_rw = 1'b0;
    tgt_req_ready = 1'b0; tgt_rdata = '0; tgt_rdata_valid = 1'b0;
    split_req = 1'b0; arbiter_grant = 1'b0;
    exp_words[0] = 8'hA1; exp_words[1] = 8'hB2; exp_words[2] = 8'hC3; exp_words[3] = 8'hD4;

    #12;
    check("rst_req_valid",   tgt_req_valid, 0);
    check("rst_rdata_ready", tgt_rdata_ready, 1);
    check("rst_fifo_count",  tx_fifo_count, 0);
    check("rst_out_valid",   bus_data_out_valid, 0);
    check("rst_rx_drop",     rx_drop, 0);
    rst_n = 1'b1;
    tick();

    // Split passthrough in both polarities
    split_req = 1'b1; arbiter_grant = 1'b0; #1;
    check("pass_split_req", arbiter_split_req, 1);
    check("pass_grant_lo",  split_grant, 0);
    split_req = 1'b0; arbiter_grant = 1'b1; #1;
    check("pass_split_lo",  arbiter_split_req, 0);
    check("pass_grant",     split_grant, 1);
    arbiter_grant = 1'b0;
    tick();

    // Read frame preceded by a wrong-mode bit
    send_bit(1'b1, 1'b1, 1'b0);
    check("wrong_mode_drop", rx_drop, 1);
    send_addr_range(16'hA5C3, 0, 14, 1'b0);
    check("rd_drop_clear",   rx_drop, 0);
    check("rd_not_yet",      tgt_req_valid, 0);
    send_addr_range(16'hA5C3, 15, 15, 1'b0);
    check("rd_valid",        tgt_req_valid, 1);
    check("rd_addr",         tgt_req_addr, 32'hA5C3);
    check("rd_write",        tgt_req_write, 0);
    check("rd_wdata",        tgt_req_wdata, 0);
    tgt_req_ready = 1'b1;
    tick();
    tgt_req_ready = 1'b0;
    check("rd_cleared_valid", tgt_req_valid, 0);
    check("rd_cleared_addr",  tgt_req_addr, 0);

    // Write frame with a stalled target and stray bits while holding
    send_addr_range(16'h0012, 0, 15, 1'b1);
    check("wr_in_data", tgt_req_valid, 0);
    send_data(8'h3C);
    check("wr_valid", tgt_req_valid, 1);
    check("wr_addr",  tgt_req_addr, 32'h0012);
    check("wr_write", tgt_req_write, 1);
    check("wr_wdata", tgt_req_wdata, 32'h3C);
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin
        send_bit(1'b1, 1'b1, 1'b0);
        check("hold_drop", rx_drop, 1);
      end else begin
        tick();
        check("hold_nodrop", rx_drop, 0);
      end
      check("hold_valid", tgt_req_valid, 1);
      check("hold_addr",  tgt_req_addr, 32'h0012);
      check("hold_wdata", tgt_req_wdata, 32'h3C);
    end
    tgt_req_ready = 1'b1;
    tick();
    tgt_req_ready = 1'b0;
    check("wr_cleared_valid", tgt_req_valid, 0);
    check("wr_cleared_write", tgt_req_write, 0);
    check("wr_cleared_wdata", tgt_req_wdata, 0);

    // TX latency and bit order for 0x96
    tx_word = w96();
    push(tx_word);
    check("tx_count_t",   tx_fifo_count, 1);
    check("tx_valid_t",   bus_data_out_valid, 0);
    tick();
    check("tx_valid_t1",  bus_data_out_valid, 0);
    check("tx_count_t1",  tx_fifo_count, 0);
    for (int i = 0; i < DATA_W; i++) begin
      tick();
      check("tx96_valid", bus_data_out_valid, 1);
      check("tx96_bit",   bus_data_out, tx_word[i]);
    end
    if (PB != 0) begin
      tick();
      check("tx96_par", bus_data_out, 0);
    end
    tick();
    check("tx96_end_valid", bus_data_out_valid, 0);
    check("tx96_hold",      bus_data_out, (PB != 0) ? 0 : 1);

    // FIFO full while the serializer is busy with a first word
    push(8'h11);
    begin
      int n;
      n = 0;
      while (!bus_data_out_valid && n < 40) begin
        tick();
        n++;
      end
      check("full_w0_start", (n < 40), 1);
    end
    for (int i = 0; i < 4; i++) push(exp_words[i]);
    check("full_ready", tgt_rdata_ready, 0);
    check("full_count", tx_fifo_count, 4);
    push(8'hE5);
    check("full_count_5th", tx_fifo_count, 4);
    wait_tx_idle("full_w0_end");
    for (int i = 0; i < 4; i++) begin
      recv_word("full_word", rw_word, rw_par);
      check("full_order", rw_word, exp_words[i]);
    end
    check("full_empty", tx_fifo_count, 0);
    check("full_ready_back", tgt_rdata_ready, 1);

    // Half-duplex: a bit arriving mid-shift is dropped and does not advance the frame
    send_addr_range(16'hBEEF, 0, 3, 1'b0);
    push(8'h55);
    tick();
    tick();
    check("hd_shifting", bus_data_out_valid, 1);
    send_bit(1'b1, 1'b0, 1'b0);
    check("hd_drop", rx_drop, 1);
    wait_tx_idle("hd_tx_end");
    tick();
    send_addr_range(16'hBEEF, 4, 15, 1'b0);
    check("hd_valid", tgt_req_valid, 1);
    check("hd_addr",  tgt_req_addr, 32'hBEEF);
    tgt_req_ready = 1'b1;
    tick();
    tgt_req_ready = 1'b0;

    // Reset in the middle of an address
    send_addr_range(16'h1234, 0, 4, 1'b0);
    push(8'h3A);
    rst_n = 1'b0;
    #2;
    check("mrst_req_valid",   tgt_req_valid, 0);
    check("mrst_addr",        tgt_req_addr, 0);
    check("mrst_drop",        rx_drop, 0);
    check("mrst_out_valid",   bus_data_out_valid, 0);
    check("mrst_out",         bus_data_out, 0);
    check("mrst_count",       tx_fifo_count, 0);
    check("mrst_rdata_ready", tgt_rdata_ready, 1);
    rst_n = 1'b1;
    tick();
    send_addr_range(16'h1234, 0, 15, 1'b0);
    check("post_rst_valid", tgt_req_valid, 1);
    check("post_rst_addr",  tgt_req_addr, 32'h1234);
    check("post_rst_tx",    bus_data_out_valid, 0);
    tgt_req_ready = 1'b1;
    tick();
    tgt_req_ready = 1'b0;

`ifdef SERIAL_TGT_PARITY_EN
    // Bad address parity discards the frame; TX word 0x07 carries parity 1
    send_addr_range(16'h0001, 0, 14, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("par_drop",     rx_drop, 1);
    check("par_no_req",   tgt_req_valid, 0);
    tick();
    check("par_no_req2",  tgt_req_valid, 0);
    send_addr_range(16'h0002, 0, 15, 1'b0);
    check("par_recover",  tgt_req_addr, 32'h0002);
    tgt_req_ready = 1'b1;
    tick();
    tgt_req_ready = 1'b0;
    push(8'h07);
    recv_word("par_tx", rw_word, rw_par);
    check("par_tx_word",  rw_word, 32'h07);
    check("par_tx_bit9",  rw_par, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
